// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcode/op fields
// and writeback mux selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

endpackage

// File: rtl/instr_dec.sv
// Instruction field extraction and immediate sign extension; purely combinational.
import cpu_pkg::*;

module instr_dec (
  input  logic [15:0] i_ir,
  output logic [2:0]  o_opcode,
  output logic [1:0]  o_op,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [1:0]  o_sh,
  output logic [2:0]  o_rm,
  output logic [15:0] o_sximm8,
  output logic [15:0] o_sximm5
);

  assign o_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle controller: holds the instruction register and steps the register
// file / ALU datapath through one instruction at a time with Moore outputs.
//
// state    | meaning
// WAIT     | idle, w=1; load captures IR, s starts an instruction
// DECODE   | classify IR; flags undefined opcodes
// GET_A    | read Rn into A
// GET_B    | read Rm into B
// EXEC     | ALU result into C, or status for CMP
// WR_REG   | write C to Rd
// WR_IMM   | write sximm8 to Rn
import cpu_pkg::*;

module instr_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic              w,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic              illegal
);

  logic [DATA_W-1:0] r_ir;
  state_t            r_state;
  state_t            w_next;

  logic [2:0] w_opcode, w_rn, w_rd, w_rm;
  logic [1:0] w_op, w_sh;
  logic       w_mov_imm, w_mov_reg, w_alu, w_cmp;

  instr_dec u_dec (
    .i_ir     (r_ir),
    .o_opcode (w_opcode),
    .o_op     (w_op),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_sh     (w_sh),
    .o_rm     (w_rm),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5)
  );

  assign w_mov_imm = (w_opcode == OPC_MOV) && (w_op == OP_MOV_IMM);
  assign w_mov_reg = (w_opcode == OPC_MOV) && (w_op == OP_MOV_REG);
  assign w_alu     = (w_opcode == OPC_ALU);
  assign w_cmp     = w_alu && (w_op == OP_CMP);

  assign ALUop = w_op;
  assign shift = w_mov_imm ? 2'b00 : w_sh;

  // IR only moves in WAIT, so a load during a busy instruction is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && load) r_ir <= in;
    end
  end

  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    illegal  = 1'b0;
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_mov_imm)                        w_next = S_WR_IMM;
        else if (w_mov_reg)                   w_next = S_GET_B;
        else if (w_alu && w_op == OP_MVN)     w_next = S_GET_B;
        else if (w_alu)                       w_next = S_GET_A;
        else begin
          illegal = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GET_B;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        asel = w_mov_reg;
        if (w_cmp) begin
          loads  = 1'b1;
          w_next = S_WAIT;
        end else begin
          loadc  = 1'b1;
          w_next = S_WR_REG;
        end
      end
      S_WR_REG: begin
        writenum = w_rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        w_next   = S_WAIT;
      end
      S_WR_IMM: begin
        writenum = w_rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
        w_next   = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: latency/write table, hand-written
// corner sequences and randomized instructions against a per-cycle trace model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  instr_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
    logic [1:0]  vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, aluop;
    logic [15:0] sximm8, sximm5;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    int          lat;
    int          writes;
    int          wn;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = '{w:w, write:write, loada:loada, loadb:loadb, loadc:loadc, loads:loads,
          asel:asel, bsel:bsel, illegal:illegal, vsel:vsel, readnum:readnum,
          writenum:writenum, shift:shift, aluop:ALUop, sximm8:sximm8, sximm5:sximm5};
    return o;
  endfunction

  // IR-derived fields, all control quiet
  function automatic obs_t base(input logic [15:0] ins);
    obs_t o;
    o        = '0;
    o.aluop  = ins[12:11];
    o.shift  = (ins[15:13] == 3'b110 && ins[12:11] == 2'b10) ? 2'b00 : ins[4:3];
    o.sximm8 = {{8{ins[7]}}, ins[7:0]};
    o.sximm5 = {{11{ins[4]}}, ins[4:0]};
    return o;
  endfunction

  // Expected output for every cycle after the start edge, ending with the idle cycle
  task automatic build_trace(input logic [15:0] ins);
    obs_t   c;
    logic   mov_imm, mov_reg, alu, is_cmp, is_mvn;
    mov_imm = ins[15:13] == 3'b110 && ins[12:11] == 2'b10;
    mov_reg = ins[15:13] == 3'b110 && ins[12:11] == 2'b00;
    alu     = ins[15:13] == 3'b101;
    is_cmp  = alu && ins[12:11] == 2'b01;
    is_mvn  = alu && ins[12:11] == 2'b11;
    exp_q.delete();
    c = base(ins);
    c.illegal = !(mov_imm || mov_reg || alu);
    exp_q.push_back(c);
    if (mov_imm) begin
      c = base(ins); c.write = 1; c.writenum = ins[10:8]; c.vsel = 2'b10;
      exp_q.push_back(c);
    end else if (mov_reg || alu) begin
      if (alu && !is_mvn) begin
        c = base(ins); c.readnum = ins[10:8]; c.loada = 1;
        exp_q.push_back(c);
      end
      c = base(ins); c.readnum = ins[2:0]; c.loadb = 1;
      exp_q.push_back(c);
      c = base(ins); c.asel = mov_reg;
      if (is_cmp) c.loads = 1; else c.loadc = 1;
      exp_q.push_back(c);
      if (!is_cmp) begin
        c = base(ins); c.write = 1; c.writenum = ins[7:5]; c.vsel = 2'b00;
        exp_q.push_back(c);
      end
    end
    c = base(ins); c.w = 1;
    exp_q.push_back(c);
  endtask

  // Start one instruction from WAIT and compare each cycle with the model;
  // with junk=1, random s/load/in are thrown at the DUT while it is busy.
  task automatic run_model(input logic [15:0] ins, input bit junk);
    build_trace(ins);
    @(negedge clk);
    in = ins; load = 1; s = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("trace %h cyc%0d", ins, i), 64'(observe()), 64'(exp_q[i]));
      if (junk && i < exp_q.size() - 1) begin
        in = 16'($urandom); load = 1'($urandom); s = 1'($urandom);
      end else begin
        load = 0; s = 0;
      end
    end
  endtask

  task automatic measure(input logic [15:0] ins, output int lat, output int writes, output int wn);
    lat = 0; writes = 0; wn = 0;
    @(negedge clk);
    in = ins; load = 1; s = 1;
    while (lat < 20) begin
      @(negedge clk);
      load = 0; s = 0;
      lat++;
      if (write) begin writes++; wn = int'(writenum); end
      if (w) break;
    end
  endtask

  initial begin
    int   lat, writes, wn, wcount;
    obs_t e;

    vecs[0]  = '{16'hD007, 3, 1, 0};
    vecs[1]  = '{16'hD1FE, 3, 1, 1};
    vecs[2]  = '{16'hA140, 6, 1, 2};
    vecs[3]  = '{16'hA900, 5, 0, 0};
    vecs[4]  = '{16'h0000, 2, 0, 0};
    vecs[5]  = '{16'hC0E1, 5, 1, 7};
    vecs[6]  = '{16'hB8A2, 5, 1, 5};
    vecs[7]  = '{16'hB260, 6, 1, 3};
    vecs[8]  = '{16'hD800, 2, 0, 0};
    vecs[9]  = '{16'hC800, 2, 0, 0};
    vecs[10] = '{16'hE000, 2, 0, 0};
    vecs[11] = '{16'hF7FF, 2, 0, 0};

    reset = 1; s = 0; load = 0; in = 16'h0;
    repeat (2) @(negedge clk);
    e = base(16'h0); e.w = 1;
    chk("reset state", 64'(observe()), 64'(e));
    reset = 0;

    foreach (vecs[k]) begin
      measure(vecs[k].ins, lat, writes, wn);
      chk($sformatf("latency %h", vecs[k].ins), 64'(lat), 64'(vecs[k].lat));
      chk($sformatf("writes %h", vecs[k].ins), 64'(writes), 64'(vecs[k].writes));
      chk($sformatf("writenum %h", vecs[k].ins), 64'(wn), 64'(vecs[k].wn));
    end

    // MOV R0,#7: write strobe on the second edge after start
    @(negedge clk);
    in = 16'hD007; load = 1; s = 1;
    @(negedge clk); load = 0; s = 0;
    @(negedge clk);
    chk("movimm write", {write, writenum, vsel, sximm8}, {1'b1, 3'd0, 2'b10, 16'h0007});
    @(negedge clk);
    chk("movimm done", {w, write}, {1'b1, 1'b0});

    // reset asserted in GET_B of ADD; reset also beats s/load
    @(negedge clk);
    in = 16'hA140; load = 1; s = 1;
    @(negedge clk); load = 0; s = 0;
    @(negedge clk);
    @(negedge clk);
    chk("add getb", {loadb, readnum}, {1'b1, 3'd0});
    reset = 1; in = 16'hD007; load = 1; s = 1;
    @(negedge clk);
    chk("reset mid", {w, write, loadc, ALUop, sximm8}, {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000});
    @(negedge clk);
    chk("reset beats s", {w, sximm8}, {1'b1, 16'h0000});
    reset = 0; load = 0; s = 0;
    wcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (write) wcount++;
    end
    chk("no write after reset", {31'(wcount), w}, {31'd0, 1'b1});

    run_model(16'hA140, 0);
    run_model(16'hA900, 1);
    run_model(16'h0000, 1);
    run_model(16'hD1FE, 1);

    for (int r = 0; r < 40; r++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ins[15:13] = 3'b101;
        1: ins[15:13] = 3'b110;
        2: ins[15:13] = 3'b101;
        default: ;
      endcase
      run_model(ins, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
